// File: rtl/vm_change_dispenser.sv
// vm_change_dispenser
//   Payout end of the vending-machine change interface. Collects the
//   coins owed from a one-cycle change code and drives the hopper one coin
//   at a time. Each coin uses an eject pulse and waits for the hopper's
//   coin_sns pulse. A missing coin_sns is supervised by a timeout, which
//   latches a fault until clr_fault is asserted.
//
// Ports
//   clk, rst   clock; synchronous active-high reset
//   change     coins to add; a nonzero value is valid for one cycle
//   coin_sns   one-cycle pulse from the hopper exit sensor
//   clr_fault  leaves FAULT and clears the fault flag
//   eject      hopper solenoid drive
//   busy       high when state != IDLE or pending != 0 (combinational)
//   pending    coins still owed, saturating at 15
//   paid       one-cycle pulse for each accepted coin_sns
//   done       one-cycle pulse when an accepted coin brings pending to 0
//   fault      high while in FAULT
//   ovf        sticky saturation flag; cleared only by rst
module vm_change_dispenser #(
  parameter int unsigned PULSE_CYC   = 4,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] change,
  input  logic       coin_sns,
  input  logic       clr_fault,
  output logic       eject,
  output logic       busy,
  output logic [3:0] pending,
  output logic       paid,
  output logic       done,
  output logic       fault,
  output logic       ovf
);

  localparam int unsigned CMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_WAIT,
    S_GAP,
    S_FAULT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;   // shared by the PULSE and GAP phases
  logic [TW-1:0] tcnt;  // counts from the eject rise until coin_sns
  logic          accept;
  logic [4:0]    sum;
  logic          sat;

  // A coin is accepted only while eject is active or awaiting the sensor.
  // pending is always >= 1 in PULSE and WAIT, so sum cannot underflow.
  always_comb begin
    accept = coin_sns && ((state == S_PULSE) || (state == S_WAIT));
    sum    = 5'(pending) + 5'(change) - 5'(accept);
    sat    = (sum > 5'd15);
    busy   = (state != S_IDLE) || (pending != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      tcnt    <= '0;
      pending <= '0;
      eject   <= 1'b0;
      paid    <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      pending <= sat ? 4'hf : sum[3:0];
      if (sat)
        ovf <= 1'b1;
      paid <= accept;
      // sum == 0 after an accept implies no simultaneous add
      done <= accept && (sum == 5'd0);

      case (state)
        S_IDLE: begin
          eject <= 1'b0;
          if (pending != 4'd0) begin
            state <= S_PULSE;
            eject <= 1'b1;
            cnt   <= '0;
            tcnt  <= '0;
          end
        end
        S_PULSE: begin
          tcnt <= tcnt + 1'b1;
          if (accept) begin
            state <= S_GAP;
            eject <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CW'(PULSE_CYC - 1)) begin
            state <= S_WAIT;
            eject <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          eject <= 1'b0;
          tcnt  <= tcnt + 1'b1;
          if (accept) begin
            state <= S_GAP;
            cnt   <= '0;
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            state <= S_FAULT;
            fault <= 1'b1;
          end
        end
        S_GAP: begin
          eject <= 1'b0;
          if (cnt == CW'(GAP_CYC - 1)) begin
            if (pending != 4'd0) begin
              state <= S_PULSE;
              eject <= 1'b1;
              cnt   <= '0;
              tcnt  <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FAULT: begin
          eject <= 1'b0;
          if (clr_fault) begin
            state <= S_IDLE;
            fault <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          eject <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// tb_vm_change_dispenser
//   Directed bench for vm_change_dispenser with default parameters
//   (PULSE_CYC=4, GAP_CYC=2, TIMEOUT_CYC=16). A vector table covers reset,
//   a three-coin payout and ignored coin_sns pulses. Hand-written sequences
//   cover timeout/fault recovery, a simultaneous add and accept,
//   saturation with ovf, and reset in the middle of a payout.
module tb_vm_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] change;
  logic       coin_sns;
  logic       clr_fault;
  logic       eject;
  logic       busy;
  logic [3:0] pending;
  logic       paid;
  logic       done;
  logic       fault;
  logic       ovf;

  int npass  = 0;
  int ntotal = 0;

  vm_change_dispenser #(
    .PULSE_CYC  (4),
    .GAP_CYC    (2),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .change   (change),
    .coin_sns (coin_sns),
    .clr_fault(clr_fault),
    .eject    (eject),
    .busy     (busy),
    .pending  (pending),
    .paid     (paid),
    .done     (done),
    .fault    (fault),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] change;
    logic       coin;
    logic       clr;
    logic       eject;
    logic       busy;
    logic [3:0] pending;
    logic       paid;
    logic       done;
    logic       fault;
    logic       ovf;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Inputs are applied, one rising edge passes, and outputs settle by #1.
  task automatic cyc(input logic r, input logic [2:0] ch, input logic cs,
                     input logic cf);
    rst = r; change = ch; coin_sns = cs; clr_fault = cf;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_eject();
    for (int i = 0; i < 40 && !eject; i++) cyc(0, 0, 0, 0);
    chk("eject_rise", eject, 1);
  endtask

  // Pays one coin, with coin_sns on the third eject-high cycle.
  task automatic pay_one(input int exp_pend, input int exp_done,
                         input int exp_ovf);
    wait_eject();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("eject_held", eject, 1);
    cyc(0, 0, 1, 0);
    chk("pay_paid", paid, 1);
    chk("pay_pending", pending, exp_pend);
    chk("pay_done", done, exp_done);
    chk("pay_eject_low", eject, 0);
    chk("pay_ovf", ovf, exp_ovf);
  endtask

  initial begin
    rst = 1'b1; change = '0; coin_sns = 1'b0; clr_fault = 1'b0;

    // Each row lists rst, change, coin, and clr, then eject, busy, pending,
    // paid, done, fault, and ovf after the edge.
    tbl[0]  = '{1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 3, 0, 0,  0, 1, 3, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0,  1, 1, 3, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0,  1, 1, 3, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0,  1, 1, 3, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 1, 0,  0, 1, 2, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0,  0, 1, 2, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0,  1, 1, 2, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0,  1, 1, 2, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0,  1, 1, 2, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 1, 0,  0, 1, 1, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0};
    tbl[15] = '{0, 0, 1, 0,  0, 1, 0, 1, 1, 0, 0};
    tbl[16] = '{0, 0, 1, 0,  0, 1, 0, 0, 0, 0, 0};  // coin_sns in GAP
    tbl[17] = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[18] = '{0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0};  // coin_sns in IDLE

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].rst, tbl[i].change, tbl[i].coin, tbl[i].clr);
      chk($sformatf("v%0d_eject", i),   eject,   tbl[i].eject);
      chk($sformatf("v%0d_busy", i),    busy,    tbl[i].busy);
      chk($sformatf("v%0d_pending", i), pending, tbl[i].pending);
      chk($sformatf("v%0d_paid", i),    paid,    tbl[i].paid);
      chk($sformatf("v%0d_done", i),    done,    tbl[i].done);
      chk($sformatf("v%0d_fault", i),   fault,   tbl[i].fault);
      chk($sformatf("v%0d_ovf", i),     ovf,     tbl[i].ovf);
    end

    // Timeout on the second coin, then recovery through clr_fault.
    cyc(0, 5, 0, 0);
    chk("f_pending5", pending, 5);
    pay_one(4, 0, 0);
    wait_eject();
    for (int j = 1; j <= 16; j++) begin
      cyc(0, 0, 0, 0);
      if (j == 15) chk("f_no_fault_early", fault, 0);
    end
    chk("f_fault", fault, 1);
    chk("f_pending4", pending, 4);
    chk("f_eject_low", eject, 0);
    chk("f_busy", busy, 1);
    cyc(0, 0, 1, 0);  // coin_sns in FAULT
    chk("f_ign_paid", paid, 0);
    chk("f_ign_pending", pending, 4);
    chk("f_still_fault", fault, 1);
    cyc(0, 0, 0, 1);
    chk("f_cleared", fault, 0);
    chk("f_pend_after_clr", pending, 4);
    pay_one(3, 0, 0);
    pay_one(2, 0, 0);
    pay_one(1, 0, 0);
    pay_one(0, 1, 0);

    // A change and a coin accept arrive in the same cycle.
    cyc(0, 1, 0, 0);
    wait_eject();
    cyc(0, 2, 1, 0);
    chk("s_pending", pending, 2);
    chk("s_paid", paid, 1);
    chk("s_no_done", done, 0);
    pay_one(1, 0, 0);
    pay_one(0, 1, 0);

    // Saturation: 14 + 4 gives 15 with ovf set, and ovf stays set.
    cyc(0, 7, 0, 0);
    cyc(0, 7, 0, 0);
    chk("o_pending14", pending, 14);
    chk("o_ovf0", ovf, 0);
    cyc(0, 4, 0, 0);
    chk("o_pending15", pending, 15);
    chk("o_ovf1", ovf, 1);
    for (int k = 14; k >= 0; k--) pay_one(k, (k == 0) ? 1 : 0, 1);

    // Reset while eject is high with three coins owed.
    cyc(0, 3, 0, 0);
    wait_eject();
    chk("r_pending3", pending, 3);
    cyc(1, 0, 0, 0);
    chk("r_eject", eject, 0);
    chk("r_pending", pending, 0);
    chk("r_busy", busy, 0);
    chk("r_ovf", ovf, 0);
    chk("r_done", done, 0);
    cyc(0, 0, 0, 0);
    chk("r_idle_eject", eject, 0);
    chk("r_idle_busy", busy, 0);
    chk("r_idle_done", done, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
